// File: rtl/req_ack_multi_gen.sv
// Multi-channel req/ack stimulus generator: each channel launches a request,
// returns a one-cycle ack after a latched latency, or times out on a dropped ack.
module req_ack_multi_gen #(
  parameter int NUM_CH    = 4,
  parameter int LAT_W     = 4,
  parameter int TIMEOUT   = 20,
  parameter int CNT_W     = 8,
  parameter bit LEVEL_REQ = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*LAT_W-1:0] ack_delay,
  input  logic [NUM_CH-1:0]       drop_ack,
  output logic [NUM_CH-1:0]       req,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       tmo,
  output logic [CNT_W-1:0]        done_cnt
);

  // TIMEOUT exceeds the largest latency, so CT_W also covers any latched delay.
  localparam int CT_W  = $clog2(TIMEOUT + 1);
  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ACK, S_TMO} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [LAT_W-1:0]  dly_q   [NUM_CH];
  logic [LAT_W-1:0]  dly_d   [NUM_CH];
  logic [CT_W-1:0]   cnt_q   [NUM_CH];
  logic [CT_W-1:0]   cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] drop_q, drop_d;
  logic [NUM_CH-1:0] req_d, ack_d, busy_d, tmo_d;
  logic [CNT_W-1:0]  done_d;
  logic [SUM_W-1:0]  sum;
  logic [LAT_W-1:0]  fld;

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    req_d  = '0;
    ack_d  = '0;
    busy_d = '0;
    tmo_d  = '0;
    drop_d = drop_q;
    fld    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      dly_d[i]   = dly_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (start[i]) begin
            fld        = ack_delay[i*LAT_W +: LAT_W];
            state_d[i] = S_ACTIVE;
            dly_d[i]   = (fld == '0) ? LAT_W'(1) : fld;
            drop_d[i]  = drop_ack[i];
            cnt_d[i]   = CT_W'(1);
            req_d[i]   = 1'b1;
            busy_d[i]  = 1'b1;
          end
        end
        S_ACTIVE: begin
          // cnt_q is the number of request cycles already seen including this one.
          busy_d[i] = 1'b1;
          if (!drop_q[i] && cnt_q[i] == CT_W'(dly_q[i])) begin
            state_d[i] = S_ACK;
            ack_d[i]   = 1'b1;
            req_d[i]   = LEVEL_REQ;
          end else if (drop_q[i] && cnt_q[i] == CT_W'(TIMEOUT)) begin
            state_d[i] = S_TMO;
            tmo_d[i]   = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CT_W'(1);
            req_d[i]   = LEVEL_REQ;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sum = SUM_W'(done_cnt);
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(ack[i]);
    end
    done_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  // NOTE: state is updated with <= so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: latched delay/drop are cleared too, so nothing from an aborted
      // transaction can leak into the next one.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        dly_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      drop_q   <= '0;
      req      <= '0;
      ack      <= '0;
      busy     <= '0;
      tmo      <= '0;
      done_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        dly_q[i]   <= dly_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      drop_q   <= drop_d;
      req      <= req_d;
      ack      <= ack_d;
      busy     <= busy_d;
      tmo      <= tmo_d;
      done_cnt <= done_d;
    end
  end

endmodule

// File: doc/req_ack_multi_gen.md
# req_ack_multi_gen

Parametrised, multi-channel successor to the single-channel req/ack stimulus generator used by the SVA test benches. Each of NUM_CH independent channels launches a request on command, returns an acknowledge after a per-request programmable latency, and can optionally drop the acknowledge so that the request times out. Pulse-request and level-request modes let one block exercise `req ##N ack` sequences, held-request properties and missing-ack failures. A saturating handshake counter gives benches non-vacuity evidence.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- LAT_W, 4: width of each per-channel ack-latency field
- TIMEOUT, 20: cycles from request start to timeout pulse on a dropped ack; must exceed 2^LAT_W-1
- CNT_W, 8: width of the handshake counter
- LEVEL_REQ, 0: 0 = req is a one-cycle pulse; 1 = req held high through the ack cycle

- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- start  in  NUM_CH  per-channel launch request, sampled on posedge
- ack_delay  in  NUM_CH*LAT_W  per-channel latency; channel i uses bits [i*LAT_W +: LAT_W]
- drop_ack  in  NUM_CH  per-channel ack suppression, sampled together with start
- req  out  NUM_CH  per-channel request
- ack  out  NUM_CH  per-channel acknowledge, one-cycle pulse
- busy  out  NUM_CH  channel has a transaction in flight
- tmo  out  NUM_CH  one-cycle timeout pulse on a dropped ack
- done_cnt  out  CNT_W  total completed handshakes, saturating

## Operation
- Per-channel FSM states are IDLE, ACTIVE, ACK and TMO. All outputs are registered.
- IDLE: if start[i]=1 at a posedge, latch d = ack_delay field and drop = drop_ack[i], then go to ACTIVE. A latched d of 0 is treated as 1.
- ACTIVE: count cycles since the request started.
  - If not dropped, go to ACK so that ack is high exactly d cycles after the first req cycle.
  - If dropped, go to TMO TIMEOUT cycles after the first req cycle.
- ACK: ack=1 for one cycle, then return to IDLE.
- TMO: tmo=1 for one cycle with req=0 and ack=0, then return to IDLE.
- start[i] while busy[i]=1 is ignored. Changes to ack_delay or drop_ack after launch have no effect on the transaction in flight.
- Channels are fully independent; any number may launch, ack or time out in the same cycle.
- done_cnt adds the number of ack bits high in a cycle (popcount, 0..NUM_CH) and saturates at 2^CNT_W-1; it never wraps. Timeouts do not count.
- Reset (asynchronous, any time, including mid-transaction): every FSM returns to IDLE, latched values are cleared, and req, ack, busy, tmo and done_cnt are all 0 immediately. Nothing is flushed or completed.

## Timing
- Naming: start is sampled at edge E; cycle C0 is the cycle after E.
- req:
  - LEVEL_REQ=0: req[i]=1 in C0 only.
  - LEVEL_REQ=1: req[i]=1 in C0..C0+d (the ack cycle included), 0 in C0+d+1.
- ack[i]=1 in cycle C0+d only. With d=1 this reproduces `req ##1 ack`.
- Dropped ack: in level mode req stays high from C0 through C0+TIMEOUT-1. tmo[i]=1 in C0+TIMEOUT with req=0.
- busy[i]=1 from C0 through the ack or tmo cycle inclusive, and 0 in the following cycle.
- Back-to-back requests: the earliest accepted restart is start sampled at the end of cycle C0+d+1, which puts the new req in C0+d+2. One idle cycle between transactions is guaranteed.
- done_cnt reflects an ack in the cycle after that ack.

## Test plan
- Reset, then start[0] pulsed with d=1, LEVEL_REQ=0 -> req[0] in C0 and ack[0] in C0+1, which is a non-vacuous `req ##1 ack` cover; done_cnt=1 in C0+2.
- Channel 1 with d=0, then d=15 -> ack at C0+1 (zero clamped to 1), then ack at C0+15; busy low the cycle after each ack.
- LEVEL_REQ=1, d=3, drop_ack=1, TIMEOUT=20 -> req high in C0..C0+19, tmo at C0+20, no ack, done_cnt unchanged.
- All four channels launched in the same cycle with d=2 -> four acks in C0+2 and done_cnt +4 in one step; with CNT_W=3 the count saturates at 7 and does not wrap.
- start held high continuously with d=2 -> acks on channel 0 every 4 cycles; start during busy is ignored; ack_delay changed mid-flight has no effect on the current transaction.
- reset_n dropped in C0+1 of a d=5 level-mode request -> req, busy and done_cnt are 0 immediately; no ack after release until a new start.
